cordic_sincos_param: RTL
========================

Name: cordic_sincos_param

Overview:
- Parametrised, partially unrolled rotation-mode CORDIC that returns both cos and sin of a signed fixed-point angle in radians.
- It is the configurable successor to the fixed 22-bit, four-stage cos-only unit in the floating-point/trig datapath. Width, iteration count and stages-per-clock are parameters.
- Uses a start/busy/done handshake and feeds the float conversion and trig blocks downstream.

Parameters:
- WIDTH, 22: total bits of angle, cos_out and sin_out (signed two's complement).
- FRAC, 20: fractional bits; format Q(WIDTH-FRAC).FRAC, so 1.0 = 2^FRAC.
- ITER, 16: total micro-rotations. Range 4..24; must be a multiple of UNROLL.
- UNROLL, 4: micro-rotations performed per clock. Range 1..ITER.
- GUARD, 2: extra LSBs carried in the internal x/y/z datapath.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  request; sampled only in IDLE
- angle  in  WIDTH  signed radians, Q(WIDTH-FRAC).FRAC
- busy  out  1  high from the start-accept edge until done
- done  out  1  one-cycle pulse; outputs valid from this cycle
- cos_out  out  WIDTH  signed cos(angle)
- sin_out  out  WIDTH  signed sin(angle)

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset values: busy=0, done=0, cos_out=0, sin_out=0, state=IDLE, step counter=0. A reset mid-operation aborts the computation with no done pulse, and outputs return to 0.
- States: IDLE, RUN, FIN.
  - IDLE: start=1 at edge T0 latches angle and loads x=K, y=0, z=angle (all left-shifted by GUARD), then goes to RUN with busy=1.
  - RUN: each edge applies UNROLL chained micro-rotations i..i+UNROLL-1, then i += UNROLL. After the edge that completes i=ITER-1, go to FIN.
  - FIN: one edge registers cos_out/sin_out, pulses done=1, sets busy=0 and returns to IDLE.
- Latency: done is high in the cycle after edge T0+N+1, where N=ITER/UNROLL. Defaults: N=4, done 5 edges after start is accepted.
- Throughput: one operation per N+2 cycles. start is ignored while busy=1 or done=1, and angle may change freely while busy.
- Micro-rotation i:
  - d = +1 if z ≥ 0, else -1.
  - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·atan(2^-i). Shifts are arithmetic.
- Constants:
  - atan table holds atan(2^-i) for i=0..23 at 30 fractional bits, arithmetically right-shifted to FRAC+GUARD at elaboration.
  - K = 0.6072529350 at 30 fractional bits, shifted the same way. No runtime multiply.
- Output rounding: round-half-up from FRAC+GUARD to FRAC, then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. The result cos(0)=1.0 must fit, so WIDTH-FRAC ≥ 2 is required.
- Valid input range without the optional feature: |angle| ≤ π/2. Outside that range results are unspecified; there is no error flag.
- Accuracy: |error| ≤ 2^(FRAC-ITER+1) LSB for in-range inputs. Defaults: ±32 LSB.
- done and busy are never high in the same cycle.
- Back-to-back: start may be asserted in the cycle done is high; it is ignored. The earliest accepted start is in the following cycle.

Optional Feature:
- Macro: CORDIC_QUADRANT_EXT_EN.
- Defined: valid range extends to |angle| ≤ π, and WIDTH-FRAC ≥ 3 is required.
  - The load step pre-rotates. If angle > π/2: x=0, y=K, z=angle-π/2. If angle < -π/2: x=0, y=-K, z=angle+π/2. Otherwise the normal load applies.
  - No added latency.
- Undefined: normal load only; range |angle| ≤ π/2 as stated above.

Test Plan:
- Reset then angle=0x080000 (0.5), start pulsed 1 cycle (defaults) -> done exactly 5 edges after accept; cos_out=920210±32, sin_out=502713±32; busy high 5 cycles.
- angle=0 -> cos_out=1048576±32 (saturates no higher than 0x1FFFFF), sin_out=0±32.
- angle=0x300000 (-1.0) -> cos_out=566549±32, sin_out=-882344±32 (two's complement).
- start held high continuously during an operation -> exactly one done per N+2 cycles. Outputs hold between done pulses and change only at done.
- reset asserted 2 cycles after accept -> no done pulse; busy=0, cos_out=sin_out=0 next cycle. A fresh start then completes normally.
- CORDIC_QUADRANT_EXT_EN with WIDTH=23, angle=2.5 (0x280000) -> cos_out=-840060±32, sin_out=627544±32. Also sweep UNROLL=1,2,8 at defaults and confirm latency N+1.

Source files
------------

// File: rtl/cordic_sincos_param.sv
// Rotation-mode CORDIC returning cos/sin of a signed Q(WIDTH-FRAC).FRAC angle, UNROLL micro-rotations per clock.
// Latency: done pulses ITER/UNROLL+1 edges after start is accepted; start is ignored while busy or done.
// Optional CORDIC_QUADRANT_EXT_EN pre-rotates by +/-pi/2 at load to extend the input range to |angle| <= pi.
module cordic_sincos_param #(
    parameter int WIDTH  = 22,
    parameter int FRAC   = 20,
    parameter int ITER   = 16,
    parameter int UNROLL = 4,
    parameter int GUARD  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] angle,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out
);

    // One spare integer bit keeps the rotating vector clear of wrap-around.
    localparam int IW  = WIDTH + GUARD + 1;
    localparam int RW  = IW + 1;
    localparam int SHF = 30 - FRAC - GUARD;

    localparam logic signed [31:0]    K30  = 32'sd652032874;
    localparam logic signed [IW-1:0]  K_I  = IW'(K30 >>> SHF);
    localparam logic signed [RW-1:0]  RND  = RW'((2 ** GUARD) / 2);
    localparam logic signed [RW-1:0]  SMAX = RW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [RW-1:0]  SMIN = -SMAX - RW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_step;
    logic                   r_done;
    logic signed [IW-1:0]   r_x, r_y, r_z;
    logic signed [WIDTH-1:0] r_cos, r_sin;

    logic signed [IW-1:0]   w_ang;
    logic signed [IW-1:0]   w_x0, w_y0, w_z0;
    logic signed [IW-1:0]   w_x, w_y, w_z, w_xs, w_ys;
    logic [4:0]             w_idx;
    logic                   w_accept;
    logic                   w_last;

    function automatic logic signed [31:0] atan30(input logic [4:0] i);
        case (i)
            5'd0:    atan30 = 32'sd843314857;
            5'd1:    atan30 = 32'sd497837830;
            5'd2:    atan30 = 32'sd263043837;
            5'd3:    atan30 = 32'sd133525159;
            5'd4:    atan30 = 32'sd67021687;
            5'd5:    atan30 = 32'sd33543516;
            5'd6:    atan30 = 32'sd16775851;
            5'd7:    atan30 = 32'sd8388437;
            5'd8:    atan30 = 32'sd4194283;
            5'd9:    atan30 = 32'sd2097149;
            5'd10:   atan30 = 32'sd1048576;
            5'd11:   atan30 = 32'sd524288;
            5'd12:   atan30 = 32'sd262144;
            5'd13:   atan30 = 32'sd131072;
            5'd14:   atan30 = 32'sd65536;
            5'd15:   atan30 = 32'sd32768;
            5'd16:   atan30 = 32'sd16384;
            5'd17:   atan30 = 32'sd8192;
            5'd18:   atan30 = 32'sd4096;
            5'd19:   atan30 = 32'sd2048;
            5'd20:   atan30 = 32'sd1024;
            5'd21:   atan30 = 32'sd512;
            5'd22:   atan30 = 32'sd256;
            5'd23:   atan30 = 32'sd128;
            default: atan30 = 32'sd0;
        endcase
    endfunction

    function automatic logic signed [IW-1:0] atan_i(input logic [4:0] i);
        return IW'(atan30(i) >>> SHF);
    endfunction

    // Round half-up out of the guard bits, then clamp to the output range.
    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [IW-1:0] v);
        logic signed [RW-1:0] s;
        s = RW'(v) + RND;
        s = s >>> GUARD;
        if (s > SMAX) begin
            return SMAX[WIDTH-1:0];
        end else if (s < SMIN) begin
            return SMIN[WIDTH-1:0];
        end
        return s[WIDTH-1:0];
    endfunction

    assign w_ang = IW'(angle) <<< GUARD;

`ifdef CORDIC_QUADRANT_EXT_EN
    localparam logic signed [31:0]   HPI30 = 32'sd1686629713;
    localparam logic signed [IW-1:0] HPI_I = IW'(HPI30 >>> SHF);

    always_comb begin
        w_x0 = K_I;
        w_y0 = '0;
        w_z0 = w_ang;
        if (w_ang > HPI_I) begin
            w_x0 = '0;
            w_y0 = K_I;
            w_z0 = w_ang - HPI_I;
        end else if (w_ang < -HPI_I) begin
            w_x0 = '0;
            w_y0 = -K_I;
            w_z0 = w_ang + HPI_I;
        end
    end
`else
    assign w_x0 = K_I;
    assign w_y0 = '0;
    assign w_z0 = w_ang;
`endif

    always_comb begin
        w_x   = r_x;
        w_y   = r_y;
        w_z   = r_z;
        w_xs  = '0;
        w_ys  = '0;
        w_idx = '0;
        for (int k = 0; k < UNROLL; k++) begin
            w_idx = r_step + 5'(k);
            w_xs  = w_x >>> w_idx;
            w_ys  = w_y >>> w_idx;
            if (!w_z[IW-1]) begin
                w_x = w_x - w_ys;
                w_y = w_y + w_xs;
                w_z = w_z - atan_i(w_idx);
            end else begin
                w_x = w_x + w_ys;
                w_y = w_y - w_xs;
                w_z = w_z + atan_i(w_idx);
            end
        end
    end

    assign w_last = ((r_step + 5'(UNROLL)) == 5'(ITER));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_step <= '0;
            r_done <= 1'b0;
            r_cos  <= '0;
            r_sin  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_x    <= w_x0;
                r_y    <= w_y0;
                r_z    <= w_z0;
                r_step <= '0;
            end else if (r_state == S_RUN) begin
                r_x    <= w_x;
                r_y    <= w_y;
                r_z    <= w_z;
                r_step <= r_step + 5'(UNROLL);
            end else if (r_state == S_FIN) begin
                r_cos  <= round_sat(r_x);
                r_sin  <= round_sat(r_y);
                r_done <= 1'b1;
                r_step <= '0;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign cos_out = r_cos;
    assign sin_out = r_sin;

endmodule
